cdb_arbiter: RTL

//  Shares the single common data bus (CDB) among the execute-stage functional units (add, mul,
//  div, br, mem-load). Each FU presents a cdb_t result with valid; the arbiter grants one per cycle
//  and drives a registered cdb_out. It holds losers in a 1-entry buffer per FU and back-pressures

---
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of one FU result per cycle into a registered
// broadcast, with a one-entry holding buffer per FU. Define CDB_ARB_BR_PRIO_EN to give the branch FU fixed priority.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [6:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] inst;
    logic [31:0] pc;
  } cdb_t;
endpackage

// One requester lane: holding buffer plus candidate selection (held result is older, so it goes first).
module cdb_hold_slot
  import cdb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic req_valid,
  input  cdb_t req_cdb,
  input  logic win,
  output logic hold_v,
  output logic cand_v,
  output cdb_t cand
);
  cdb_t hold;

  assign cand_v = hold_v | req_valid;
  assign cand   = hold_v ? hold : req_cdb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v <= 1'b0;
      hold   <= '0;
    end else if (flush) begin
      hold_v <= 1'b0;
    end else if (win) begin
      // Draining the buffer frees it; a same-cycle new result refills it.
      if (hold_v) begin
        hold_v <= req_valid;
        if (req_valid) hold <= req_cdb;
      end
    end else if (req_valid && !hold_v) begin
      hold_v <= 1'b1;
      hold   <= req_cdb;
    end
  end
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int BR_IDX  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  cdb_t [NUM_REQ-1:0] req_cdb,
  output logic [NUM_REQ-1:0] stall,
  output logic [NUM_REQ-1:0] grant,
  output cdb_t               cdb_out
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [NUM_REQ-1:0] req_t;

`ifdef CDB_ARB_BR_PRIO_EN
  localparam bit BR_PRIO = 1'b1;
`else
  localparam bit BR_PRIO = 1'b0;
`endif

  req_t hold_v, cand_v, win_oh;
  cdb_t cand [NUM_REQ];
  ptr_t rr_ptr, win_idx;
  logic win_found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    cdb_hold_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .req_valid(req_valid[g]),
      .req_cdb  (req_cdb[g]),
      .win      (win_oh[g]),
      .hold_v   (hold_v[g]),
      .cand_v   (cand_v[g]),
      .cand     (cand[g])
    );
  end

  assign stall = hold_v;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && cand_v[idx]) begin
        win_found = 1'b1;
        win_idx   = ptr_t'(idx);
      end
    end
    if (BR_PRIO && cand_v[BR_IDX]) begin
      win_found = 1'b1;
      win_idx   = ptr_t'(BR_IDX);
    end
    win_oh = win_found ? (req_t'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_out <= '0;
      grant   <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      cdb_out <= '0;
      grant   <= '0;
    end else if (win_found) begin
      cdb_out       <= cand[win_idx];
      cdb_out.valid <= 1'b1;
      grant         <= win_oh;
      // Branch grants under fixed priority leave the rotation untouched.
      if (!(BR_PRIO && win_idx == ptr_t'(BR_IDX)))
        rr_ptr <= (win_idx == ptr_t'(NUM_REQ - 1)) ? '0 : win_idx + ptr_t'(1);
    end else begin
      cdb_out <= '0;
      grant   <= '0;
    end
  end

  // A new result arriving while the lane's buffer is full and not draining is lost.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst || flush)
    (req_valid & hold_v & ~win_oh) == '0);
endmodule
